// File: rtl/mux_2x1_rr_arb.sv
// Two-channel round-robin arbiter feeding one registered valid/ready output.
// Define MUX_ARB_CNT_EN to add saturating per-channel grant counters.
module mux_2x1_rr_arb #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [W-1:0]     b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [W-1:0]     y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             s0
`ifdef MUX_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  logic last;
  logic load;
  logic gnt_a;
  logic gnt_b;

  assign load = !y_valid | y_ready;

  // last = 1 means b was served most recently, so a wins a tie
  assign gnt_a = a_valid & (!b_valid | last);
  assign gnt_b = b_valid & (!a_valid | !last);

  assign a_ready = rst_n & load & gnt_a;
  assign b_ready = rst_n & load & gnt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      s0      <= 1'b0;
      last    <= 1'b1;
    end else if (load) begin
      if (gnt_a | gnt_b) begin
        y       <= gnt_b ? b : a;
        y_valid <= 1'b1;
        s0      <= gnt_b;
        last    <= gnt_b;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_CNT_EN
  logic a_xfer;
  logic b_xfer;

  assign a_xfer = a_valid & a_ready;
  assign b_xfer = b_valid & b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_xfer && cnt_a != '1)
        cnt_a <= cnt_a + 1'b1;
      if (b_xfer && cnt_b != '1)
        cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_2x1_rr_arb.sv
// Directed self-checking bench for mux_2x1_rr_arb.
// Counter checks are compiled in when MUX_ARB_CNT_EN is defined.
module tb_mux_2x1_rr_arb;

  localparam int W     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     a, b, y;
  logic             a_valid, b_valid, y_ready;
  logic             a_ready, b_ready, y_valid, s0;
`ifdef MUX_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_a, cnt_b;
`endif

  int n_chk = 0;
  int n_err = 0;

  mux_2x1_rr_arb #(.W(W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .s0      (s0)
`ifdef MUX_ARB_CNT_EN
    ,
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b1;

    // reset with both channels requesting
    #1;
    chk("rst_ardy", a_ready, 0);
    chk("rst_brdy", b_ready, 0);
    tick();
    tick();
    chk("rst_y", y, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_s0", s0, 0);
    chk("rst_ardy2", a_ready, 0);

    // single channel a
    rst_n   = 1'b1;
    a       = 8'h11;
    b_valid = 1'b0;
    #1;
    chk("sgl_ardy", a_ready, 1);
    chk("sgl_brdy", b_ready, 0);
    tick();
    chk("sgl_y", y, 8'h11);
    chk("sgl_yv", y_valid, 1);
    chk("sgl_s0", s0, 0);

    // contention from reset
    rst_pulse();
    chk("rp_yv", y_valid, 0);
    a       = 8'hAA;
    b       = 8'hBB;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ctn_ardy", a_ready, (i % 2) == 0);
      chk("ctn_brdy", b_ready, (i % 2) == 1);
      tick();
      chk("ctn_y", y, (i % 2) ? 8'hBB : 8'hAA);
      chk("ctn_s0", s0, i % 2);
      chk("ctn_yv", y_valid, 1);
    end

    // backpressure holds BB
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ardy", a_ready, 0);
      chk("bp_brdy", b_ready, 0);
      tick();
      chk("bp_y", y, 8'hBB);
      chk("bp_s0", s0, 1);
      chk("bp_yv", y_valid, 1);
    end
    y_ready = 1'b1;
    #1;
    chk("bpr_ardy", a_ready, 1);
    tick();
    chk("bpr_y", y, 8'hAA);
    chk("bpr_s0", s0, 0);
    chk("bpr_yv", y_valid, 1);

    // async reset between edges drops the beat
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_yv", y_valid, 0);
    chk("ar_y", y, 0);
    chk("ar_ardy", a_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("ar_y2", y, 8'hAA);
    chk("ar_s0", s0, 0);

    // idle cycle, then b only, idle, then contention: a wins
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("idle_yv", y_valid, 0);
    chk("idle_y", y, 8'hAA);
    b       = 8'h5C;
    b_valid = 1'b1;
    tick();
    chk("bonly_y", y, 8'h5C);
    chk("bonly_s0", s0, 1);
    b_valid = 1'b0;
    tick();
    chk("idle2_yv", y_valid, 0);
    chk("idle2_s0", s0, 1);
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("rot_ardy", a_ready, 1);
    tick();
    chk("rot_y", y, 8'hAA);
    chk("rot_s0", s0, 0);

`ifdef MUX_ARB_CNT_EN
    // 3 a-grants and 2 b-grants, then one more a-grant
    rst_pulse();
    chk("cnt_rst_a", cnt_a, 0);
    chk("cnt_rst_b", cnt_b, 0);
    for (int i = 0; i < 4; i++)
      tick();
    b_valid = 1'b0;
    tick();
    chk("cnt_a3", cnt_a, 3);
    chk("cnt_b2", cnt_b, 2);
    tick();
    chk("cnt_asat", cnt_a, 3);
    chk("cnt_bhold", cnt_b, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
